// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD converter scheduler.
//   BIN_W   : width of a binary operand handed to the converter
//   BCD_W   : width of a packed 4-digit BCD result
//   BCD_ERR : result reported when a conversion is aborted by the watchdog
//   state_e : scheduler FSM states
package bcd_pkg;

  localparam int unsigned BIN_W = 13;
  localparam int unsigned BCD_W = 16;

  localparam logic [BCD_W-1:0] BCD_ERR = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request scanning upward from ptr_i, wrapping at NREQ.
//   req_i : request vector
//   ptr_i : index with highest priority this cycle
//   gnt_o : one-hot grant (all zero when no request)
//   idx_o : encoded index of the granted request (0 when no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdW-1:0]  idx_o
);

  logic           found;
  logic [IdW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IdW'((32'(ptr_i) + k) % NREQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_sched.sv
// Shares one binary-to-BCD converter between NREQ requesters.
// One job at a time: accept (IDLE) -> start pulse (ISSUE) -> wait for done or
// watchdog (WAIT) -> hold response until consumed (RESP).
//   clk, reset_n            : clock, asynchronous active-low reset
//   req_valid/req_bin       : per-requester request and packed 13-bit operands
//   req_ready               : one-hot, one-cycle accept strobe
//   conv_start/conv_bin     : converter start pulse and held operand
//   conv_done/conv_bcd      : converter result pulse and 16-bit BCD value
//   rsp_valid/rsp_ready     : response handshake
//   rsp_id/rsp_bcd/rsp_err  : requester index, result, watchdog-abort flag
//   busy                    : scheduler is not idle
module bcd_conv_sched
  import bcd_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned TIMEOUT = 31
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*BIN_W-1:0] req_bin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  conv_start,
  output logic [BIN_W-1:0]      conv_bin,
  input  logic                  conv_done,
  input  logic [BCD_W-1:0]      conv_bcd,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [BCD_W-1:0]      rsp_bcd,
  output logic                  rsp_err,
  output logic                  busy
);

  // Last WAIT cycle before the watchdog aborts the job.
  localparam logic [7:0] WdLast = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]       wd_cnt_q, wd_cnt_d;
  logic [BIN_W-1:0] conv_bin_q, conv_bin_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [BCD_W-1:0] rsp_bcd_q, rsp_bcd_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic [BIN_W-1:0] sel_bin;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  // Operand of the granted requester.
  always_comb begin
    sel_bin = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) sel_bin = req_bin[i*BIN_W +: BIN_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wd_cnt_d   = wd_cnt_q;
    conv_bin_d = conv_bin_q;
    grant_id_d = grant_id_q;
    rsp_bcd_d  = rsp_bcd_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    conv_start = 1'b0;
    rsp_valid  = 1'b0;

    case (state_q)
      StIdle: begin
        if (|req_valid) begin
          req_ready  = arb_gnt;
          conv_bin_d = sel_bin;
          grant_id_d = arb_idx;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        conv_start = 1'b1;
        wd_cnt_d   = '0;
        state_d    = StWait;
      end
      StWait: begin
        wd_cnt_d = wd_cnt_q + 8'd1;
        // A result on the terminal watchdog cycle still counts as valid.
        if (conv_done) begin
          rsp_bcd_d = conv_bcd;
          rsp_err_d = 1'b0;
          state_d   = StResp;
        end else if (wd_cnt_q == WdLast) begin
          rsp_bcd_d = BCD_ERR;
          rsp_err_d = 1'b1;
          state_d   = StResp;
        end
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rr_ptr_d = (grant_id_q == ID_W'(NREQ - 1)) ? '0 : grant_id_q + ID_W'(1);
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      wd_cnt_q   <= '0;
      conv_bin_q <= '0;
      grant_id_q <= '0;
      rsp_bcd_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wd_cnt_q   <= wd_cnt_d;
      conv_bin_q <= conv_bin_d;
      grant_id_q <= grant_id_d;
      rsp_bcd_q  <= rsp_bcd_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign conv_bin = conv_bin_q;
  assign rsp_id   = grant_id_q;
  assign rsp_bcd  = rsp_bcd_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Bench for bcd_conv_sched: directed scenarios plus a randomized phase, all
// checked every cycle against a transaction/timestamp model of the scheduler.
module tb_bcd_conv_sched;

  localparam int NREQ    = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 31;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ*13-1:0] req_bin;
  logic [NREQ-1:0]  req_ready;
  logic             conv_start;
  logic [12:0]      conv_bin;
  logic             conv_done;
  logic [15:0]      conv_bcd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [15:0]      rsp_bcd;
  logic             rsp_err;
  logic             busy;

  always #5 clk = ~clk;

  bcd_conv_sched #(
    .NREQ    (NREQ),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_bin    (req_bin),
    .req_ready  (req_ready),
    .conv_start (conv_start),
    .conv_bin   (conv_bin),
    .conv_done  (conv_done),
    .conv_bcd   (conv_bcd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_bcd    (rsp_bcd),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Requester side
  logic [NREQ-1:0] pend;
  logic [12:0]     pend_bin [NREQ];
  bit              rand_req, rand_rsp, rand_conv;
  int              conv_delay, conv_cnt;

  // Model: one outstanding job described by timestamps
  bit          m_active, m_end_known, m_err;
  int          m_ptr, m_id, m_tacc, m_tend;
  logic [12:0] m_bin;
  logic [15:0] m_bcd;

  // Observations of the DUT
  bit          prev_valid;
  int          obs_tstart, obs_tvalid;
  int          log_id[$], log_err[$], log_lat[$], log_hs[$];
  logic [15:0] log_bcd[$];
  int          acc_id[$], acc_cyc[$];

  function automatic logic [15:0] bin2bcd(input int v);
    bin2bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired waiting for DUT (cycle %0d)", name, cyc);
  endtask

  task automatic drive_req();
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) req_bin[i*13 +: 13] = pend_bin[i];
  endtask

  task automatic raise(input int i, input int v);
    pend[i]     = 1'b1;
    pend_bin[i] = 13'(v);
    drive_req();
  endtask

  // One clock: check and advance the model at negedge, drive inputs after posedge.
  task automatic tick();
    int              w;
    logic [NREQ-1:0] exp_ready;
    bit              exp_valid;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_conv_start", 32'(conv_start), 0);
      chk("rst_conv_bin", 32'(conv_bin), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_bcd", 32'(rsp_bcd), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_busy", 32'(busy), 0);
      m_active = 0; m_end_known = 0; m_ptr = 0;
      prev_valid = 0;
    end else begin
      w = pick(req_valid, m_ptr);
      exp_ready = '0;
      if (!m_active && w >= 0) exp_ready[w] = 1'b1;
      exp_valid = m_active && m_end_known && (cyc >= m_tend);
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("conv_start", 32'(conv_start), 32'(m_active && (cyc == m_tacc + 1)));
      chk("busy", 32'(busy), 32'(m_active));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (m_active) chk("conv_bin", 32'(conv_bin), 32'(m_bin));
      if (exp_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_bcd", 32'(rsp_bcd), 32'(m_bcd));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
      end
      if (conv_start) obs_tstart = cyc;
      if (rsp_valid && !prev_valid) obs_tvalid = cyc;
      prev_valid = rsp_valid;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      end
      if (rsp_valid && rsp_ready) begin
        log_id.push_back(int'(rsp_id));
        log_bcd.push_back(rsp_bcd);
        log_err.push_back(int'(rsp_err));
        log_lat.push_back(obs_tvalid - obs_tstart);
        log_hs.push_back(cyc);
      end
      if (exp_valid) begin
        if (rsp_ready) begin
          m_active = 0;
          m_ptr    = (m_id + 1) % NREQ;
        end
      end else if (!m_active) begin
        if (w >= 0) begin
          m_active    = 1;
          m_end_known = 0;
          m_tacc      = cyc;
          m_id        = w;
          m_bin       = req_bin[w*13 +: 13];
        end
      end else if (!m_end_known) begin
        if (conv_done && cyc >= m_tacc + 2) begin
          m_end_known = 1; m_tend = cyc + 1; m_err = 0; m_bcd = bin2bcd(int'(m_bin));
        end else if (cyc == m_tacc + 1 + TIMEOUT) begin
          m_end_known = 1; m_tend = cyc + 1; m_err = 1; m_bcd = 16'hFFFF;
        end
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) pend[i] = 1'b0;
      if (conv_start) conv_cnt = rand_conv ? int'($urandom_range(1, TIMEOUT + 4)) : conv_delay;
    end
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    conv_bcd  = 16'($urandom);
    if (conv_cnt > 0) begin
      conv_cnt--;
      if (conv_cnt == 0) begin
        conv_done = 1'b1;
        conv_bcd  = bin2bcd(int'(conv_bin));
      end
    end
    if (rand_req) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 5) == 0) begin
          pend[i]     = 1'b1;
          pend_bin[i] = 13'($urandom_range(0, 8191));
        end
      end
    end
    if (rand_rsp) rsp_ready = ($urandom_range(0, 3) != 0);
    drive_req();
  endtask

  task automatic wait_rsp(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (log_id.size() < n && k < budget) begin tick(); k++; end
    if (log_id.size() < n) fail_bound(name);
  endtask

  task automatic wait_acc(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (acc_id.size() < n && k < budget) begin tick(); k++; end
    if (acc_id.size() < n) fail_bound(name);
  endtask

  initial begin
    int          b, a, h, k;
    int          exp_id[5];
    logic [15:0] exp_bcd[5];
    exp_id  = '{0, 1, 2, 3, 0};
    exp_bcd = '{16'h8191, 16'h0000, 16'h0042, 16'h0999, 16'h0500};

    reset_n = 1'b0; req_valid = '0; req_bin = '0; conv_done = 1'b0; conv_bcd = '0;
    rsp_ready = 1'b0; pend = '0;
    for (int i = 0; i < NREQ; i++) pend_bin[i] = '0;
    rand_req = 0; rand_rsp = 0; rand_conv = 0; conv_delay = 0; conv_cnt = 0;
    m_active = 0; m_end_known = 0; m_err = 0; m_ptr = 0; m_id = 0; m_tacc = 0; m_tend = 0;
    m_bin = '0; m_bcd = '0; prev_valid = 0; obs_tstart = 0; obs_tvalid = 0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Single request, converter answers 14 cycles after start
    rsp_ready = 1'b1; conv_delay = 14;
    b = log_id.size(); a = acc_id.size();
    raise(0, 1234);
    wait_rsp(b + 1, 80, "t1_wait");
    chk("t1_acc_id", 32'(acc_id[a]), 0);
    chk("t1_id", 32'(log_id[b]), 0);
    chk("t1_bcd", 32'(log_bcd[b]), 32'h1234);
    chk("t1_err", 32'(log_err[b]), 0);
    chk("t1_lat", 32'(log_lat[b]), 15);

    // Round robin from a freshly reset pointer; requester 0 re-requests
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    conv_delay = 3;
    b = log_id.size(); a = acc_id.size();
    raise(0, 8191); raise(1, 0); raise(2, 42); raise(3, 999);
    wait_acc(a + 1, 20, "t2_acc0");
    raise(0, 500);
    wait_rsp(b + 5, 200, "t2_wait");
    for (int i = 0; i < 5; i++) begin
      chk("t2_id", 32'(log_id[b+i]), 32'(exp_id[i]));
      chk("t2_bcd", 32'(log_bcd[b+i]), 32'(exp_bcd[i]));
    end

    // Backpressure with a competing request waiting
    rsp_ready = 1'b0; conv_delay = 5;
    b = log_id.size();
    raise(2, 4321);
    k = 0;
    while (!rsp_valid && k < 60) begin tick(); k++; end
    if (!rsp_valid) fail_bound("t3_valid");
    raise(1, 777);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", 32'(rsp_valid), 1);
      chk("t3_hold_bcd", 32'(rsp_bcd), 32'h4321);
      chk("t3_hold_id", 32'(rsp_id), 2);
      chk("t3_hold_busy", 32'(busy), 1);
      chk("t3_hold_ready", 32'(req_ready), 0);
    end
    a = acc_id.size(); h = log_hs.size();
    rsp_ready = 1'b1;
    wait_acc(a + 1, 10, "t3_acc");
    chk("t3_acc_id", 32'(acc_id[a]), 1);
    chk("t3_acc_gap", 32'(acc_cyc[a] - log_hs[h]), 1);
    wait_rsp(b + 2, 60, "t3_wait");
    chk("t3_bcd2", 32'(log_bcd[b+1]), 32'h0777);

    // Watchdog abort, then a normal conversion
    conv_delay = 0;
    b = log_id.size();
    raise(3, 55);
    wait_rsp(b + 1, 80, "t4_wait");
    chk("t4_id", 32'(log_id[b]), 3);
    chk("t4_err", 32'(log_err[b]), 1);
    chk("t4_bcd", 32'(log_bcd[b]), 32'hFFFF);
    chk("t4_lat", 32'(log_lat[b]), 32);
    conv_delay = 3;
    raise(3, 6789);
    wait_rsp(b + 2, 40, "t4_wait2");
    chk("t4_err2", 32'(log_err[b+1]), 0);
    chk("t4_bcd2", 32'(log_bcd[b+1]), 32'h6789);

    // Done on the terminal watchdog cycle
    conv_delay = TIMEOUT;
    b = log_id.size();
    raise(1, 2024);
    wait_rsp(b + 1, 80, "t5_wait");
    chk("t5_err", 32'(log_err[b]), 0);
    chk("t5_bcd", 32'(log_bcd[b]), 32'h2024);
    chk("t5_lat", 32'(log_lat[b]), 32);

    // Reset while waiting on the converter, then a late done pulse
    conv_delay = 20;
    b = log_id.size();
    raise(3, 111);
    k = 0;
    while (!conv_start && k < 10) begin tick(); k++; end
    if (!conv_start) fail_bound("t6_start");
    repeat (5) tick();
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
    conv_done = 1'b1; conv_bcd = 16'h1111;
    repeat (5) tick();
    chk("t6_no_rsp", 32'(log_id.size()), 32'(b));
    chk("t6_valid", 32'(rsp_valid), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_conv_bin", 32'(conv_bin), 0);
    chk("t6_rsp_bcd", 32'(rsp_bcd), 0);
    a = acc_id.size();
    conv_delay = 4;
    raise(3, 5); raise(1, 6);
    wait_acc(a + 1, 10, "t6_acc");
    chk("t6_first_grant", 32'(acc_id[a]), 1);
    wait_rsp(b + 2, 100, "t6_wait");

    // Randomized traffic
    rand_conv = 1; rand_req = 1; rand_rsp = 1;
    repeat (4000) tick();
    rand_req = 0; rand_rsp = 0; rsp_ready = 1'b1;
    k = 0;
    while ((pend != '0 || busy) && k < 2000) begin tick(); k++; end
    if (pend != '0 || busy) fail_bound("drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_conv_sched.md
Name: bcd_conv_sched

Overview:
- Round-robin scheduler that shares one binary-to-BCD converter between NREQ requesters, e.g. the IR command decoder, repeat counter and address display.
- Accepts one 13-bit value per grant, sequences the converter with a start/done handshake and returns the 16-bit packed BCD result tagged with the requester id.
- Includes a watchdog so a hung conversion cannot lock the shared resource.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width (must equal clog2(NREQ)).
- TIMEOUT, 31, cycles allowed in WAIT before abort (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request. Held high with stable req_bin until accepted.
- req_bin  in  NREQ*13  packed values, slice i = req_bin[13*i+12 : 13*i].
- req_ready  out  NREQ  one-hot accept strobe, one cycle.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_bin  out  13  operand to the converter, stable from start until done.
- conv_done  in  1  converter result-valid pulse.
- conv_bcd  in  16  converter result, 4 digits, digit 3 in [15:12].
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  ID_W  requester index of the response.
- rsp_bcd  out  16  BCD result.
- rsp_err  out  1  response is a timeout abort.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous while reset_n=0:
  - state=IDLE, rr_ptr=0, wd_cnt=0.
  - All outputs 0, including conv_bin, rsp_bcd and rsp_id.
  - Reset mid-conversion abandons the job. No start is reissued after reset, and a later conv_done is ignored.
- IDLE:
  - If any req_valid, pick the winner g = first set bit scanning from rr_ptr upward, wrapping at NREQ.
  - Drive req_ready[g]=1 combinationally in the same cycle.
  - Latch conv_bin=req_bin slice g and grant_id=g, then go to ISSUE.
  - If no req_valid, stay in IDLE with req_ready=0.
- ISSUE: conv_start=1 for exactly one cycle, wd_cnt cleared, go to WAIT.
- WAIT:
  - wd_cnt increments each cycle.
  - conv_done=1: rsp_bcd<=conv_bcd, rsp_err<=0, go to RESP.
  - conv_done=0 and wd_cnt==TIMEOUT-1: rsp_bcd<=16'hFFFF, rsp_err<=1, go to RESP.
  - conv_done and timeout in the same cycle: done wins and the result is valid.
- RESP:
  - rsp_valid=1 and rsp_id=grant_id, held stable until rsp_ready.
  - On rsp_valid&rsp_ready: rr_ptr<=(grant_id+1) mod NREQ, then go to IDLE.
  - rsp_ready in the same cycle as rsp_valid rises completes in 1 cycle.
- Latency:
  - Accept to conv_start: 1 cycle.
  - conv_done to rsp_valid: 1 cycle.
  - rsp handshake to next accept: 1 cycle, because IDLE is visited.
- conv_done is ignored outside WAIT.
- req_ready is never asserted outside IDLE, and at most one bit is set.
- Fairness: a continuously requesting source waits at most NREQ-1 grants.
- rr_ptr wraps NREQ-1 to 0.
- Value range: 13-bit max 8191 fits in 4 BCD digits, so no overflow handling is needed.
- Illegal state encodings return to IDLE.

Decomposition:
- Shared package bcd_pkg holds:
  - BIN_W=13, BCD_W=16.
  - State encoding IDLE/ISSUE/WAIT/RESP.
  - BCD_ERR=16'hFFFF.
- Sub-module rr_arbiter (parameter NREQ): inputs req vector and rr_ptr; outputs one-hot grant and encoded index.
  - Purely combinational.
  - Reused by other shared-resource blocks.

Test Plan:
- Single request: req_valid=0001, req_bin[0]=13'd1234, converter model returns after 14 cycles, rsp_ready=1. Expect req_ready=0001 for one cycle, conv_start one cycle later, then rsp_bcd=16'h1234, rsp_id=0, rsp_err=0.
- Round-robin: all four valid with values 8191, 0, 42, 999 and continuous rsp_ready. Expect grant order 0,1,2,3 and results 16'h8191, 16'h0000, 16'h0042, 16'h0999. A new request on 0 is then served after 3.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid. Expect rsp_valid, rsp_bcd and rsp_id held stable, req_ready=0 and busy=1 throughout. Accept proceeds 1 cycle after rsp_ready.
- Timeout: the converter never asserts done, TIMEOUT=31. Expect rsp_valid TIMEOUT+1 cycles after conv_start with rsp_err=1 and rsp_bcd=16'hFFFF. The next request then converts normally.
- Done/timeout collision: conv_done on the terminal watchdog cycle. Expect rsp_err=0 and the converter value captured.
- Reset in WAIT: drop reset_n for 2 cycles, then pulse conv_done. Expect all outputs 0, no response generated, rr_ptr=0, and the next grant going to the lowest valid requester.
